// File: rtl/imm_gen_stage_pkg.sv
// Shared definitions for the immediate generator stage: format codes,
// RV32/RV64 major opcodes and the skid-buffer state encoding.
// Optional feature macro: IMM_ZICSR_EN (CSR uimm decoding as format Z).
package imm_gen_stage_pkg;

    // Width of the format code carried with each immediate
    localparam int IMM_TYPE_W = 3;

    // Immediate format codes
    localparam logic [IMM_TYPE_W-1:0] FMT_R   = 3'd0;
    localparam logic [IMM_TYPE_W-1:0] FMT_I   = 3'd1;
    localparam logic [IMM_TYPE_W-1:0] FMT_S   = 3'd2;
    localparam logic [IMM_TYPE_W-1:0] FMT_B   = 3'd3;
    localparam logic [IMM_TYPE_W-1:0] FMT_U   = 3'd4;
    localparam logic [IMM_TYPE_W-1:0] FMT_J   = 3'd5;
    localparam logic [IMM_TYPE_W-1:0] FMT_Z   = 3'd6;
    localparam logic [IMM_TYPE_W-1:0] FMT_ILL = 3'd7;

    // Major opcodes (inst[6:0])
    localparam logic [6:0] OPC_OP        = 7'b0110011;
    localparam logic [6:0] OPC_OP_32     = 7'b0111011;
    localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_LOAD      = 7'b0000011;
    localparam logic [6:0] OPC_JALR      = 7'b1100111;
    localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;
    localparam logic [6:0] OPC_STORE     = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
    localparam logic [6:0] OPC_LUI       = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
    localparam logic [6:0] OPC_JAL       = 7'b1101111;

    // Occupancy of the 2-entry output buffer
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } buf_state_e;

endpackage

// File: rtl/imm_decode.sv
// Combinational immediate decoder: opcode -> format code and the
// sign-extended XLEN immediate.
// Optional feature macro: IMM_ZICSR_EN (SYSTEM with funct3[2]=1 -> format Z).
module imm_decode
    import imm_gen_stage_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int TYPE_W = IMM_TYPE_W
) (
    input  logic [31:0]       i_inst,
    output logic [XLEN-1:0]   o_imm,
    output logic [TYPE_W-1:0] o_type
);

    logic [31:0]           w_imm32;
    logic [IMM_TYPE_W-1:0] w_fmt;

    // Select the format from the opcode and assemble the 32-bit immediate
    always_comb begin
        w_fmt   = FMT_ILL;
        w_imm32 = '0;
        case (i_inst[6:0])
            OPC_OP, OPC_OP_32: begin
                w_fmt = FMT_R;
            end
            OPC_OP_IMM, OPC_LOAD, OPC_JALR, OPC_OP_IMM_32: begin
                // Shift amounts are passed through raw as part of the I value
                w_fmt   = FMT_I;
                w_imm32 = {{20{i_inst[31]}}, i_inst[31:20]};
            end
            OPC_SYSTEM: begin
`ifdef IMM_ZICSR_EN
                if (i_inst[14]) begin
                    // CSR immediate forms: 5-bit uimm in the rs1 field
                    w_fmt   = FMT_Z;
                    w_imm32 = {27'd0, i_inst[19:15]};
                end else begin
                    w_fmt   = FMT_I;
                    w_imm32 = {{20{i_inst[31]}}, i_inst[31:20]};
                end
`else
                w_fmt   = FMT_I;
                w_imm32 = {{20{i_inst[31]}}, i_inst[31:20]};
`endif
            end
            OPC_STORE: begin
                w_fmt   = FMT_S;
                w_imm32 = {{20{i_inst[31]}}, i_inst[31:25], i_inst[11:7]};
            end
            OPC_BRANCH: begin
                w_fmt   = FMT_B;
                w_imm32 = {{19{i_inst[31]}}, i_inst[31], i_inst[7],
                           i_inst[30:25], i_inst[11:8], 1'b0};
            end
            OPC_LUI, OPC_AUIPC: begin
                w_fmt   = FMT_U;
                w_imm32 = {i_inst[31:12], 12'd0};
            end
            OPC_JAL: begin
                w_fmt   = FMT_J;
                w_imm32 = {{11{i_inst[31]}}, i_inst[31], i_inst[19:12],
                           i_inst[20], i_inst[30:21], 1'b0};
            end
            default: begin
                w_fmt   = FMT_ILL;
                w_imm32 = '0;
            end
        endcase
    end

    assign o_type = TYPE_W'(w_fmt);

    // Low word is the assembled value; bit 31 is replicated up to XLEN
    // (the Z value has bit 31 clear, so it stays zero-extended).
    assign o_imm[31:0] = w_imm32;

    genvar gi;
    generate
        for (gi = 32; gi < XLEN; gi++) begin : g_sext
            assign o_imm[gi] = w_imm32[31];
        end
    endgenerate

endmodule

// File: rtl/imm_gen_stage.sv
// Pipelined immediate generator: decodes each accepted instruction and
// holds the result in a 2-entry skid buffer (head drives the outputs, the
// second entry absorbs one beat of backpressure so in_ready can be taken
// from registered state only).
// Optional feature macro: IMM_ZICSR_EN (passed through to imm_decode).
module imm_gen_stage
    import imm_gen_stage_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int TYPE_W = IMM_TYPE_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_inst,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   out_imm,
    output logic [TYPE_W-1:0] out_type,
    output logic [31:0]       out_inst
);

    buf_state_e r_state;
    buf_state_e w_state_next;

    logic [XLEN-1:0]   r_head_imm;
    logic [TYPE_W-1:0] r_head_type;
    logic [31:0]       r_head_inst;
    logic [XLEN-1:0]   r_skid_imm;
    logic [TYPE_W-1:0] r_skid_type;
    logic [31:0]       r_skid_inst;

    logic [XLEN-1:0]   w_dec_imm;
    logic [TYPE_W-1:0] w_dec_type;

    logic w_push;
    logic w_pop;
    logic w_load_head_new;
    logic w_load_head_skid;
    logic w_load_skid;

    imm_decode #(
        .XLEN   (XLEN),
        .TYPE_W (TYPE_W)
    ) u_decode (
        .i_inst (in_inst),
        .o_imm  (w_dec_imm),
        .o_type (w_dec_type)
    );

    // in_ready depends on the registered state (and reset) only
    assign in_ready  = (r_state != ST_FULL) && !rst;
    assign out_valid = (r_state != ST_EMPTY);
    assign out_imm   = r_head_imm;
    assign out_type  = r_head_type;
    assign out_inst  = r_head_inst;

    assign w_push = in_valid && in_ready;
    assign w_pop  = out_valid && out_ready;

    // Next occupancy and which entry register loads this cycle
    always_comb begin
        w_state_next     = r_state;
        w_load_head_new  = 1'b0;
        w_load_head_skid = 1'b0;
        w_load_skid      = 1'b0;
        case (r_state)
            ST_EMPTY: begin
                if (w_push) begin
                    w_state_next    = ST_ONE;
                    w_load_head_new = 1'b1;
                end
            end
            ST_ONE: begin
                if (w_push && w_pop) begin
                    // Head leaves and the new entry replaces it directly
                    w_state_next    = ST_ONE;
                    w_load_head_new = 1'b1;
                end else if (w_push) begin
                    w_state_next = ST_FULL;
                    w_load_skid  = 1'b1;
                end else if (w_pop) begin
                    w_state_next = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (w_pop) begin
                    w_state_next     = ST_ONE;
                    w_load_head_skid = 1'b1;
                end
            end
            default: begin
                w_state_next = ST_EMPTY;
            end
        endcase
        // Flush drops everything, including an input accepted this cycle
        if (flush) begin
            w_state_next     = ST_EMPTY;
            w_load_head_new  = 1'b0;
            w_load_head_skid = 1'b0;
            w_load_skid      = 1'b0;
        end
    end

    // Occupancy state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Head and skid entry registers; head only changes on a load, so the
    // outputs hold steady while the consumer stalls
    always_ff @(posedge clk) begin
        if (rst) begin
            r_head_imm  <= '0;
            r_head_type <= '0;
            r_head_inst <= '0;
            r_skid_imm  <= '0;
            r_skid_type <= '0;
            r_skid_inst <= '0;
        end else begin
            if (w_load_head_new) begin
                r_head_imm  <= w_dec_imm;
                r_head_type <= w_dec_type;
                r_head_inst <= in_inst;
            end else if (w_load_head_skid) begin
                r_head_imm  <= r_skid_imm;
                r_head_type <= r_skid_type;
                r_head_inst <= r_skid_inst;
            end
            if (w_load_skid) begin
                r_skid_imm  <= w_dec_imm;
                r_skid_type <= w_dec_type;
                r_skid_inst <= in_inst;
            end
        end
    end

endmodule

// File: tb/tb_imm_gen_stage.sv
// Self-checking bench for imm_gen_stage: a table of single instructions
// checked on both an XLEN=32 and an XLEN=64 instance, followed by
// hand-written backpressure, flush and reset sequences.
// Honours IMM_ZICSR_EN for the CSR-immediate expectation.
module tb_imm_gen_stage;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] imm;
        logic [2:0]  typ;
    } vec_t;

    localparam int NVEC = 13;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic [31:0] in_inst;
    logic        out_ready;

    logic        in_ready;
    logic        out_valid;
    logic [31:0] out_imm;
    logic [2:0]  out_type;
    logic [31:0] out_inst;

    logic        in_ready64;
    logic        out_valid64;
    logic [63:0] out_imm64;
    logic [2:0]  out_type64;
    logic [31:0] out_inst64;

    int total;
    int bad;

    vec_t vecs [NVEC];

    imm_gen_stage #(.XLEN(32), .TYPE_W(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_inst   (in_inst),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_imm   (out_imm),
        .out_type  (out_type),
        .out_inst  (out_inst)
    );

    imm_gen_stage #(.XLEN(64), .TYPE_W(3)) dut64 (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready64),
        .in_inst   (in_inst),
        .out_valid (out_valid64),
        .out_ready (out_ready),
        .out_imm   (out_imm64),
        .out_type  (out_type64),
        .out_inst  (out_inst64)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string what, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", what, act, exp);
        end
    endtask

    initial begin
        logic [63:0] exp64;
        logic [31:0] held_imm;

        total = 0;
        bad   = 0;

        vecs[0]  = '{32'hFFF00093, 32'hFFFFFFFF, 3'd1};   // addi x1,x0,-1
        vecs[1]  = '{32'hFE112E23, 32'hFFFFFFFC, 3'd2};   // sw x1,-4(x2)
        vecs[2]  = '{32'hFE000CE3, 32'hFFFFFFF8, 3'd3};   // beq -8
        vecs[3]  = '{32'h123452B7, 32'h12345000, 3'd4};   // lui x5,0x12345
        vecs[4]  = '{32'h001000EF, 32'h00000800, 3'd5};   // jal +2048
        vecs[5]  = '{32'h0000007F, 32'h00000000, 3'd7};   // illegal opcode
        vecs[6]  = '{32'h002081B3, 32'h00000000, 3'd0};   // add x3,x1,x2
        vecs[7]  = '{32'h80000017, 32'h80000000, 3'd4};   // auipc, top bit set
        vecs[8]  = '{32'h7FF0A083, 32'h000007FF, 3'd1};   // lw, largest positive I
        vecs[9]  = '{32'hFFDFF0EF, 32'hFFFFFFFC, 3'd5};   // jal -4
        vecs[10] = '{32'h0010809B, 32'h00000001, 3'd1};   // addiw
        vecs[11] = '{32'h30029073, 32'h00000300, 3'd1};   // csrrw stays I
`ifdef IMM_ZICSR_EN
        vecs[12] = '{32'h3002D073, 32'h00000005, 3'd6};   // csrrwi -> Z, uimm 5
`else
        vecs[12] = '{32'h3002D073, 32'h00000300, 3'd1};   // csrrwi -> I
`endif

        rst       = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_inst   = 32'h0;
        out_ready = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_in_ready_low", {63'd0, in_ready}, 64'd0);
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", {63'd0, in_ready}, 64'd1);
        check("post_rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("post_rst_out_imm", {32'd0, out_imm}, 64'd0);
        check("post_rst_out_type", {61'd0, out_type}, 64'd0);
        check("post_rst_out_inst", {32'd0, out_inst}, 64'd0);

        // Table: one instruction at a time, one-cycle latency
        out_ready = 1'b1;
        for (int i = 0; i < NVEC; i++) begin
            @(negedge clk);
            check("vec_in_ready", {63'd0, in_ready}, 64'd1);
            in_valid = 1'b1;
            in_inst  = vecs[i].inst;
            @(negedge clk);
            in_valid = 1'b0;
            exp64 = {{32{vecs[i].imm[31]}}, vecs[i].imm};
            $display("vec %0d inst=%08h imm=%08h type=%0d imm64=%016h", i,
                     vecs[i].inst, out_imm, out_type, out_imm64);
            check("vec_out_valid", {63'd0, out_valid}, 64'd1);
            check("vec_out_imm", {32'd0, out_imm}, {32'd0, vecs[i].imm});
            check("vec_out_type", {61'd0, out_type}, {61'd0, vecs[i].typ});
            check("vec_out_inst", {32'd0, out_inst}, {32'd0, vecs[i].inst});
            check("vec64_out_valid", {62'd0, out_valid64, in_ready64}, 64'd3);
            check("vec64_out_imm", out_imm64, exp64);
            check("vec64_out_type", {61'd0, out_type64}, {61'd0, vecs[i].typ});
            check("vec64_out_inst", {32'd0, out_inst64}, {32'd0, vecs[i].inst});
        end
        @(negedge clk);
        check("drain_out_valid", {63'd0, out_valid}, 64'd0);

        // Backpressure: A, B, C back to back with the consumer stalled
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_inst   = 32'hFFF00093;                          // A
        @(negedge clk);
        $display("bp accept A: in_ready=%0b out_valid=%0b inst=%08h", in_ready, out_valid, out_inst);
        check("bp_after_A_in_ready", {63'd0, in_ready}, 64'd1);
        check("bp_after_A_inst", {32'd0, out_inst}, 64'hFFF00093);
        in_inst = 32'hFE112E23;                            // B
        @(negedge clk);
        $display("bp accept B: in_ready=%0b out_valid=%0b inst=%08h", in_ready, out_valid, out_inst);
        check("bp_after_B_in_ready", {63'd0, in_ready}, 64'd0);
        check("bp_after_B_inst", {32'd0, out_inst}, 64'hFFF00093);
        held_imm = out_imm;
        in_inst = 32'h123452B7;                            // C, must be held
        @(negedge clk);
        $display("bp hold C: in_ready=%0b out_valid=%0b inst=%08h", in_ready, out_valid, out_inst);
        check("bp_hold_in_ready", {63'd0, in_ready}, 64'd0);
        check("bp_hold_out_valid", {63'd0, out_valid}, 64'd1);
        check("bp_hold_inst", {32'd0, out_inst}, 64'hFFF00093);
        check("bp_hold_imm_stable", {32'd0, out_imm}, {32'd0, held_imm});
        out_ready = 1'b1;
        @(negedge clk);
        $display("bp drain B: in_ready=%0b out_valid=%0b inst=%08h", in_ready, out_valid, out_inst);
        check("bp_drain_B_inst", {32'd0, out_inst}, 64'hFE112E23);
        check("bp_drain_B_imm", {32'd0, out_imm}, 64'hFFFFFFFC);
        check("bp_drain_B_in_ready", {63'd0, in_ready}, 64'd1);
        @(negedge clk);
        $display("bp drain C: in_ready=%0b out_valid=%0b inst=%08h", in_ready, out_valid, out_inst);
        check("bp_drain_C_inst", {32'd0, out_inst}, 64'h123452B7);
        check("bp_drain_C_imm", {32'd0, out_imm}, 64'h12345000);
        check("bp_drain_C_type", {61'd0, out_type}, 64'd4);
        in_valid = 1'b0;
        @(negedge clk);
        check("bp_empty", {63'd0, out_valid}, 64'd0);

        // Flush while FULL with a concurrent input
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_inst   = 32'hFFF00093;
        @(negedge clk);
        in_inst = 32'hFE112E23;
        @(negedge clk);
        check("fl_full_in_ready", {63'd0, in_ready}, 64'd0);
        flush   = 1'b1;
        in_inst = 32'h123452B7;
        @(negedge clk);
        $display("flush full: out_valid=%0b in_ready=%0b", out_valid, in_ready);
        check("fl_full_out_valid", {63'd0, out_valid}, 64'd0);
        check("fl_full_in_ready_back", {63'd0, in_ready}, 64'd1);

        // Flush while ONE with a push accepted in the same cycle
        flush   = 1'b0;
        in_inst = 32'hFE000CE3;
        @(negedge clk);
        check("fl_one_out_valid_pre", {63'd0, out_valid}, 64'd1);
        flush   = 1'b1;
        in_inst = 32'h001000EF;
        @(negedge clk);
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        $display("flush one: out_valid=%0b", out_valid);
        check("fl_one_out_valid", {63'd0, out_valid}, 64'd0);
        @(negedge clk);
        check("fl_one_nothing_emitted", {63'd0, out_valid}, 64'd0);

        // Reset mid-operation with the buffer full
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_inst   = 32'hFFF00093;
        @(negedge clk);
        in_inst = 32'hFE112E23;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_in_ready", {63'd0, in_ready}, 64'd0);
        rst       = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        $display("reset mid-op: out_valid=%0b inst=%08h", out_valid, out_inst);
        check("rst_mid_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_mid_out_inst", {32'd0, out_inst}, 64'd0);
        @(negedge clk);
        check("rst_mid_in_ready_back", {63'd0, in_ready}, 64'd1);
        check("rst_mid_stay_empty", {63'd0, out_valid}, 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
